// File: rtl/pulse_pkg.sv
// Shared types for the pulse-domain sequencer: descriptor layout, FSM states.
package pulse_pkg;

  localparam int CH_W  = 4;
  localparam int WF_W  = 8;
  localparam int AMP_W = 16;
  localparam int PH_W  = 16;
  localparam int DLY_W = 12;
  localparam int DUR_W = 8;
  localparam int DESC_W = CH_W + WF_W + AMP_W + PH_W + DLY_W + DUR_W;

  // MSB first, matching the word the core-side handler pushes into the FIFO
  typedef struct packed {
    logic [CH_W-1:0]  channel;
    logic [WF_W-1:0]  waveform_id;
    logic [AMP_W-1:0] amplitude;
    logic [PH_W-1:0]  phase;
    logic [DLY_W-1:0] delay;
    logic [DUR_W-1:0] duration;
  } pulse_descriptor_t;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_DELAY = 2'd1,
    SEQ_PLAY  = 2'd2
  } seq_state_t;

  // A zero duration still plays for one cycle
  function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] dur);
    return (dur == '0) ? DUR_W'(1) : dur;
  endfunction

endpackage

// File: rtl/pulse_prefetch_buf.sv
// One-entry prefetch: pops the FIFO, captures the word a cycle later, and
// presents it to the sequencer. The captured word is also offered on the
// capture cycle itself so a load can happen without waiting for the register.
module pulse_prefetch_buf #(
  parameter int DESC_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic              fifo_empty,
  input  logic [DESC_W-1:0] fifo_rdata,
  input  logic              consume,
  output logic              fifo_rd_en,
  output logic              rd_pending,
  output logic              next_valid,
  output logic [DESC_W-1:0] next_q
);

  logic              buf_valid_q, buf_valid_d;
  logic              rd_pending_q, rd_pending_d;
  logic [DESC_W-1:0] buf_q, buf_d;

  // Single outstanding read; never pop over a held descriptor
  assign fifo_rd_en = !reset && !fifo_empty && !buf_valid_q && !rd_pending_q && !abort;
  assign rd_pending = rd_pending_q;
  assign next_valid = buf_valid_q || (rd_pending_q && !abort);
  assign next_q     = buf_valid_q ? buf_q : fifo_rdata;

  // Capture / consume / abort bookkeeping for the single entry
  always_comb begin
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    rd_pending_d = fifo_rd_en;
    if (abort) begin
      buf_valid_d  = 1'b0;
      rd_pending_d = 1'b0;
    end else if (consume) begin
      buf_valid_d = 1'b0;
    end else if (rd_pending_q) begin
      buf_valid_d = 1'b1;
      buf_d       = fifo_rdata;
    end
  end

  // Entry state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      rd_pending_q <= rd_pending_d;
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Pulse-domain sequencer: waits each descriptor's delay, then plays its
// fields onto the waveform-generator interface for its duration.
module pulse_sequencer #(
  parameter int DESC_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              abort,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DESC_W-1:0] fifo_rdata,
  output logic              pulse_active,
  output logic              pulse_first,
  output logic [3:0]        pulse_channel,
  output logic [7:0]        pulse_waveform_id,
  output logic [15:0]       pulse_amplitude,
  output logic [15:0]       pulse_phase,
  output logic              seq_idle,
  output logic [CNT_W-1:0]  pulse_count
);
  import pulse_pkg::*;

  seq_state_t        state_q, state_d;
  pulse_descriptor_t cur_q, cur_d, desc_in;
  logic [DLY_W-1:0]  dly_cnt_q, dly_cnt_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic              pulse_active_q, pulse_active_d;
  logic              pulse_first_q, pulse_first_d;
  logic [3:0]        pulse_channel_q, pulse_channel_d;
  logic [7:0]        pulse_waveform_id_q, pulse_waveform_id_d;
  logic [15:0]       pulse_amplitude_q, pulse_amplitude_d;
  logic [15:0]       pulse_phase_q, pulse_phase_d;
  logic [CNT_W-1:0]  pulse_count_q, pulse_count_d;
  logic              load, next_valid, rd_pending;
  logic [DESC_W-1:0] next_q;

  pulse_prefetch_buf #(.DESC_W(DESC_W)) u_prefetch (
    .clk        (clk),
    .reset      (reset),
    .abort      (abort),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .consume    (load),
    .fifo_rd_en (fifo_rd_en),
    .rd_pending (rd_pending),
    .next_valid (next_valid),
    .next_q     (next_q)
  );

  assign desc_in = next_q;

  // Next state, counters and registered-output values
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    dly_cnt_d = dly_cnt_q;
    dur_cnt_d = dur_cnt_q;
    load      = 1'b0;
    if (abort) begin
      state_d = SEQ_IDLE;
    end else begin
      case (state_q)
        SEQ_IDLE: load = next_valid && enable;
        SEQ_DELAY: begin
          dly_cnt_d = dly_cnt_q - 1'b1;
          if (dly_cnt_q == DLY_W'(1)) begin
            state_d   = SEQ_PLAY;
            dur_cnt_d = eff_dur(cur_q.duration);
          end
        end
        SEQ_PLAY: begin
          dur_cnt_d = dur_cnt_q - 1'b1;
          if (dur_cnt_q == DUR_W'(1)) begin
            state_d = SEQ_IDLE;
            load    = next_valid && enable;
          end
        end
        default: state_d = SEQ_IDLE;
      endcase
      if (load) begin
        cur_d = desc_in;
        if (desc_in.delay == '0) begin
          state_d   = SEQ_PLAY;
          dur_cnt_d = eff_dur(desc_in.duration);
        end else begin
          state_d   = SEQ_DELAY;
          dly_cnt_d = desc_in.delay;
        end
      end
    end
    pulse_active_d      = (state_d == SEQ_PLAY);
    pulse_first_d       = pulse_active_d && ((state_q != SEQ_PLAY) || load);
    pulse_channel_d     = pulse_active_d ? cur_d.channel     : '0;
    pulse_waveform_id_d = pulse_active_d ? cur_d.waveform_id : '0;
    pulse_amplitude_d   = pulse_active_d ? cur_d.amplitude   : '0;
    pulse_phase_d       = pulse_active_d ? cur_d.phase       : '0;
    pulse_count_d       = pulse_count_q + CNT_W'(pulse_first_d);
  end

  // FSM, counters and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q             <= SEQ_IDLE;
      cur_q               <= '0;
      dly_cnt_q           <= '0;
      dur_cnt_q           <= '0;
      pulse_active_q      <= 1'b0;
      pulse_first_q       <= 1'b0;
      pulse_channel_q     <= '0;
      pulse_waveform_id_q <= '0;
      pulse_amplitude_q   <= '0;
      pulse_phase_q       <= '0;
      pulse_count_q       <= '0;
    end else begin
      state_q             <= state_d;
      cur_q               <= cur_d;
      dly_cnt_q           <= dly_cnt_d;
      dur_cnt_q           <= dur_cnt_d;
      pulse_active_q      <= pulse_active_d;
      pulse_first_q       <= pulse_first_d;
      pulse_channel_q     <= pulse_channel_d;
      pulse_waveform_id_q <= pulse_waveform_id_d;
      pulse_amplitude_q   <= pulse_amplitude_d;
      pulse_phase_q       <= pulse_phase_d;
      pulse_count_q       <= pulse_count_d;
    end
  end

  assign pulse_active      = pulse_active_q;
  assign pulse_first       = pulse_first_q;
  assign pulse_channel     = pulse_channel_q;
  assign pulse_waveform_id = pulse_waveform_id_q;
  assign pulse_amplitude   = pulse_amplitude_q;
  assign pulse_phase       = pulse_phase_q;
  assign pulse_count       = pulse_count_q;
  assign seq_idle          = (state_q == SEQ_IDLE) && !next_valid && !rd_pending && fifo_empty;

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
Pulse-domain consumer of the pulse descriptor async FIFO that the core's quantum handler fills. It prefetches one descriptor ahead and waits the descriptor's inter-pulse delay. It then drives the descriptor's channel, waveform, amplitude and phase fields onto the waveform-generator interface for its duration. Back-to-back issue is supported with zero-cycle gaps. Idle and count status go back to the core side via synchronizers that are outside this block.

Parameters:
DESC_W, 64, descriptor width; must equal the packed width of pulse_descriptor_t.
CNT_W, 16, width of the issued-pulse counter.

Ports:
clk  in  1  pulse-domain clock (FIFO read clock)
reset  in  1  reset, asynchronous, active-high
enable  in  1  when low, no new descriptor starts; the current pulse completes
abort  in  1  synchronous; kills the current pulse and discards the prefetched descriptor
fifo_empty  in  1  FIFO read-side empty
fifo_rd_en  out  1  one-cycle pop request
fifo_rdata  in  DESC_W  FIFO data, valid the cycle after fifo_rd_en
pulse_active  out  1  high on every cycle a pulse plays
pulse_first  out  1  strobe on the first cycle of each pulse
pulse_channel  out  4  target channel
pulse_waveform_id  out  8  waveform selector
pulse_amplitude  out  16  amplitude
pulse_phase  out  16  phase
seq_idle  out  1  state IDLE, no prefetched descriptor, no read pending, and fifo_empty high
pulse_count  out  CNT_W  number of pulses started; wraps modulo 2^CNT_W

Behaviour:
- Reset values:
  - All outputs 0, except seq_idle = fifo_empty.
  - State IDLE; next_valid=0; rd_pending=0; counters 0.
- Descriptor fields, MSB to LSB: channel[63:60], waveform_id[59:52], amplitude[51:36], phase[35:20], delay[19:8], duration[7:0].
- Prefetch stage:
  - fifo_rd_en=1 when !fifo_empty && !next_valid && !rd_pending && !abort.
  - fifo_rd_en sets rd_pending for the next cycle.
  - On the cycle where rd_pending=1: capture fifo_rdata into next_q, set next_valid=1, clear rd_pending.
  - At most one outstanding read. Never pop while next_valid=1.
- Load event:
  - Occurs in IDLE, or on the last PLAY cycle (dur_cnt==1), when next_valid && enable.
  - Copies next_q into the current registers and clears next_valid. A new read may issue in the following cycle.
  - If delay==0: next state PLAY, dur_cnt = duration. Otherwise: next state DELAY, dly_cnt = delay.
  - duration==0 is treated as 1.
- DELAY: dly_cnt decrements each cycle; when dly_cnt==1, next state is PLAY. DELAY lasts exactly `delay` cycles.
- PLAY:
  - pulse_active=1 and field outputs are held from the current registers.
  - pulse_first=1 only on the first cycle; pulse_count increments on that cycle.
  - dur_cnt decrements each cycle.
  - When dur_cnt==1: if a load event occurs, the transition is as above with no idle cycle between pulses; otherwise next state is IDLE.
- Field outputs are registered. Outside PLAY they are 0.
- Latency from an empty, IDLE sequencer:
  - Cycle 0: fifo_empty falls, fifo_rd_en asserts.
  - Cycle 1: capture.
  - Cycle 2: first PLAY cycle when delay=0; for delay=d, the first PLAY cycle is 2+d.
- abort (highest priority):
  - Next state IDLE; next_valid and rd_pending cleared; pulse outputs 0 next cycle.
  - Data arriving for a pending read is discarded.
  - fifo_rd_en is forced low during abort.
- enable low:
  - DELAY and PLAY proceed to completion; no load event occurs.
  - Prefetch continues, so one descriptor may be buffered.
- Reset mid-pulse: outputs drop asynchronously; the prefetched descriptor is lost.

Decomposition:
- Shared package pulse_pkg holds:
  - pulse_descriptor_t packed struct (field order above) and DESC_W;
  - SEQ_IDLE/SEQ_DELAY/SEQ_PLAY state enum;
  - field width localparams.
- One sub-module, pulse_prefetch_buf: the one-entry read-and-capture logic, with outputs next_q, next_valid and input consume.
- The FSM and counters stay in pulse_sequencer.

Test Plan:
- Single descriptor {ch=3, amp=0x1234, delay=0, dur=4} into an empty FIFO:
  - rd_en on cycle 0; pulse_active on cycles 2-5; pulse_first on cycle 2 only;
  - pulse_channel=3, amplitude=0x1234; pulse_count=1; seq_idle back to 1 on cycle 6.
- Two descriptors {delay=0, dur=3} then {delay=0, dur=2} both preloaded: pulse_active high for 5 contiguous cycles; pulse_first on the 1st and 4th; channel switches with no gap.
- Second descriptor with delay=5: exactly 5 cycles of pulse_active=0 between the pulses.
- duration=0 descriptor: exactly one PLAY cycle.
- abort on the 2nd cycle of a dur=10 pulse with a descriptor prefetched: pulse_active=0 next cycle; prefetched descriptor dropped; the next pulse comes from the following FIFO entry.
- enable=0 with 3 descriptors queued:
  - exactly one fifo_rd_en; no pulse; seq_idle=0.
  - Raise enable: pulses issue in order and pulse_count=3.
  - Preset pulse_count to 0xFFFF via 65535 pulses: it wraps to 0.
